// File: rtl/uart_rx_cfg_if.sv
// uart_rx_cfg_if: receiver-to-RX-FIFO write side plus the RTS/almost-full
// flow-control pair. The receiver uses the master modport, the FIFO side
// uses the slave modport.
interface uart_rx_cfg_if #(
  parameter int DATA_W_MAX = 9
);
  logic                  o_valid;
  logic [DATA_W_MAX-1:0] o_data;
  logic                  o_parity_error;
  logic                  o_frame_error;
  logic                  o_break;
  logic                  o_rts;
  logic                  i_fifo_almfull;

  modport master (
    output o_valid, o_data, o_parity_error, o_frame_error, o_break, o_rts,
    input  i_fifo_almfull
  );

  modport slave (
    input  o_valid, o_data, o_parity_error, o_frame_error, o_break, o_rts,
    output i_fifo_almfull
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: runtime-configurable UART receiver (5..DATA_W_MAX data bits,
// none/even/odd parity, 1/1.5/2 stop bits, MSB/LSB first, mid-bit sampling,
// false-start rejection and break detection).
// Optional macro UART_RX_MAJORITY_VOTE_EN: adds a 3-deep majority filter
// after the synchroniser to reject single-cycle glitches on the rx line.
module uart_rx_cfg #(
  parameter int DATA_W_MAX  = 9,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_bit_length,
  input  logic [3:0]       i_data_bits,
  input  logic [1:0]       i_parity_mode,
  input  logic [1:0]       i_stop_bits,
  input  logic             i_msb_first,
  input  logic             i_hw_flow_control_enable,
  input  logic             i_rx,
  output logic             o_busy,
  uart_rx_cfg_if.master    rx_bus
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE, WAIT_HIGH} state_t;

  localparam logic [3:0] MAX_BITS = 4'(DATA_W_MAX);

  state_t                state, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                  rx_s, rx_f, rx_prev, fall, start_go;
  logic [CNT_W-1:0]      cnt, len_q;
  logic [3:0]            nbits_q, bit_idx, wr_idx, data_bits_c;
  logic [1:0]            par_q;
  logic                  two_stop_q, msb_q, stop_idx;
  logic [DATA_W_MAX-1:0] word_acc, data_q;
  logic                  par_acc, perr_acc, ferr_acc, any_one;
  logic                  valid_q, perr_q, ferr_q, brk_q, rts_q;
  logic                  half_hit, full_hit, counting, parity_en, frame_end;

  // Bring the asynchronous rx line into the clock domain; idles high.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) sync_q <= '1;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], i_rx};
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [2:0] vote_q;

  // Three-sample history of rx_s; the majority of it drives every decision.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) vote_q <= '1;
    else         vote_q <= {vote_q[1:0], rx_s};
  end

  assign rx_f = (vote_q[0] & vote_q[1]) | (vote_q[0] & vote_q[2]) | (vote_q[1] & vote_q[2]);
`else
  assign rx_f = rx_s;
`endif

  // Previous line value, used to find the falling edge of a start bit.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) rx_prev <= 1'b1;
    else         rx_prev <= rx_f;
  end

  // Clamp the requested word length into the supported range.
  always_comb begin
    data_bits_c = i_data_bits;
    if (i_data_bits < 4'd5)           data_bits_c = 4'd5;
    else if (i_data_bits > MAX_BITS)  data_bits_c = MAX_BITS;
  end

  assign fall      = rx_prev & ~rx_f;
  assign start_go  = (state == IDLE) && i_enable && fall;
  assign half_hit  = (cnt == (len_q >> 1));
  assign full_hit  = (cnt == len_q);
  assign parity_en = (par_q == 2'b01) || (par_q == 2'b10);
  assign counting  = ((state == START) && !half_hit) ||
                     ((state inside {DATA, PARITY, STOP}) && !full_hit);
  assign wr_idx    = msb_q ? (nbits_q - 4'd1 - bit_idx) : bit_idx;
  assign frame_end = (state == STOP) && (state_n == DONE);

  // State register.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) state <= IDLE;
    else         state <= state_n;
  end

  // Frame sequencing: start qualification, data, parity, stop, then report.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (start_go) state_n = START;
      START:     if (half_hit) state_n = rx_f ? IDLE : DATA;
      DATA:      if (full_hit && (bit_idx == nbits_q - 4'd1))
                   state_n = parity_en ? PARITY : STOP;
      PARITY:    if (full_hit) state_n = STOP;
      STOP:      if (full_hit && (!two_stop_q || stop_idx)) state_n = DONE;
      DONE:      state_n = brk_q ? WAIT_HIGH : IDLE;
      WAIT_HIGH: if (rx_f) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // Bit timing, configuration latch, sample accumulation and result registers.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      cnt        <= '0;
      len_q      <= '0;
      nbits_q    <= 4'd5;
      par_q      <= 2'b00;
      two_stop_q <= 1'b0;
      msb_q      <= 1'b0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      word_acc   <= '0;
      par_acc    <= 1'b0;
      perr_acc   <= 1'b0;
      ferr_acc   <= 1'b0;
      any_one    <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      cnt     <= counting ? cnt + CNT_W'(1) : '0;
      valid_q <= 1'b0;
      if (start_go) begin
        len_q      <= i_bit_length;
        nbits_q    <= data_bits_c;
        par_q      <= i_parity_mode;
        two_stop_q <= i_stop_bits[1];
        msb_q      <= i_msb_first;
        bit_idx    <= '0;
        stop_idx   <= 1'b0;
        word_acc   <= '0;
        par_acc    <= 1'b0;
        perr_acc   <= 1'b0;
        ferr_acc   <= 1'b0;
        any_one    <= 1'b0;
      end
      if ((state inside {DATA, PARITY, STOP}) && full_hit)
        any_one <= any_one | rx_f;
      if ((state == DATA) && full_hit) begin
        for (int i = 0; i < DATA_W_MAX; i++)
          if (i == int'(wr_idx)) word_acc[i] <= rx_f;
        par_acc <= par_acc ^ rx_f;
        bit_idx <= bit_idx + 4'd1;
      end
      if ((state == PARITY) && full_hit)
        perr_acc <= (par_q == 2'b10) ? ~(par_acc ^ rx_f) : (par_acc ^ rx_f);
      if ((state == STOP) && full_hit) begin
        stop_idx <= 1'b1;
        if (!rx_f) ferr_acc <= 1'b1;
      end
      if (frame_end) begin
        valid_q <= 1'b1;
        data_q  <= word_acc;
        perr_q  <= perr_acc;
        ferr_q  <= ferr_acc | ~rx_f;
        brk_q   <= ~(any_one | rx_f);
      end
    end
  end

  // Flow control: deassert RTS while the FIFO reports almost full.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) rts_q <= 1'b1;
    else         rts_q <= ~(i_hw_flow_control_enable & rx_bus.i_fifo_almfull);
  end

  assign o_busy                = (state != IDLE);
  assign rx_bus.o_valid        = valid_q;
  assign rx_bus.o_data         = data_q;
  assign rx_bus.o_parity_error = perr_q;
  assign rx_bus.o_frame_error  = ferr_q;
  assign rx_bus.o_break        = brk_q;
  assign rx_bus.o_rts          = rts_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: table-driven and randomized frames for uart_rx_cfg, checked
// against a bit-list model of the serial line, plus hand sequences for false
// start, break, flow control and mid-frame reset.
module tb_uart_rx_cfg;

  typedef struct {
    int         len;
    logic [3:0] dbits;
    logic [1:0] par;
    logic [1:0] stop;
    logic       msb;
    logic [8:0] word;
    bit         flip_par;
    bit         stop2_zero;
    logic [8:0] exp_data;
    bit         exp_perr;
    bit         exp_ferr;
    bit         exp_brk;
  } vec_t;

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } res_t;

  logic        i_clk = 1'b0;
  logic        i_nrst;
  logic        i_enable;
  logic [31:0] i_bit_length;
  logic [3:0]  i_data_bits;
  logic [1:0]  i_parity_mode;
  logic [1:0]  i_stop_bits;
  logic        i_msb_first;
  logic        i_hw_flow_control_enable;
  logic        i_rx;
  logic        o_busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  res_t capq[$];
  bit   line_q[$];
  vec_t vecs[6];

  uart_rx_cfg_if #(.DATA_W_MAX(9)) bus ();

  uart_rx_cfg #(.DATA_W_MAX(9), .CNT_W(32), .SYNC_STAGES(2)) dut (
    .i_clk                    (i_clk),
    .i_nrst                   (i_nrst),
    .i_enable                 (i_enable),
    .i_bit_length             (i_bit_length),
    .i_data_bits              (i_data_bits),
    .i_parity_mode            (i_parity_mode),
    .i_stop_bits              (i_stop_bits),
    .i_msb_first              (i_msb_first),
    .i_hw_flow_control_enable (i_hw_flow_control_enable),
    .i_rx                     (i_rx),
    .o_busy                   (o_busy),
    .rx_bus                   (bus.master)
  );

  // 10 ns clock.
  always #5 i_clk = ~i_clk;

  // Capture every completed frame away from the active edge.
  always @(negedge i_clk) begin
    if (bus.o_valid === 1'b1)
      capq.push_back('{bus.o_data, bus.o_parity_error, bus.o_frame_error, bus.o_break});
  end

  // Hard time limit so the bench always ends.
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic int eff_bits(input logic [3:0] d);
    if (d < 5) return 5;
    if (d > 9) return 9;
    return int'(d);
  endfunction

  // Serial bits after the start bit: data, optional parity, stop bit(s).
  function automatic void build_line(input vec_t v);
    int nb = eff_bits(v.dbits);
    int ones = 0;
    bit b, p;
    line_q.delete();
    for (int k = 0; k < nb; k++) begin
      b = v.msb ? v.word[nb-1-k] : v.word[k];
      line_q.push_back(b);
      ones += int'(b);
    end
    if (v.par == 2'b01 || v.par == 2'b10) begin
      p = (v.par == 2'b01) ? bit'(ones % 2) : bit'(1 - ones % 2);
      line_q.push_back(p ^ v.flip_par);
    end
    line_q.push_back(1'b1);
    if (v.stop >= 2) line_q.push_back(v.stop2_zero ? 1'b0 : 1'b1);
  endfunction

  // Reference decode of the line contents from the frame format rules.
  function automatic res_t model(input vec_t v);
    res_t r;
    int nb  = eff_bits(v.dbits);
    int pos = nb;
    bit x   = 1'b0;
    bit all0 = 1'b1;
    r = '{9'h0, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < nb; k++) begin
      if (v.msb) r.data[nb-1-k] = line_q[k];
      else       r.data[k]      = line_q[k];
      x ^= line_q[k];
    end
    if (v.par == 2'b01 || v.par == 2'b10) begin
      x ^= line_q[nb];
      r.perr = (v.par == 2'b01) ? x : ~x;
      pos++;
    end
    r.ferr = (line_q[pos] == 1'b0);
    if (v.stop >= 2) r.ferr = r.ferr | (line_q[pos+1] == 1'b0);
    foreach (line_q[i]) if (line_q[i]) all0 = 1'b0;
    r.brk = all0;
    if (all0) r.ferr = 1'b1;
    return r;
  endfunction

  // Configure, send one frame (scrambling config and enable mid-frame),
  // then leave the line idle for two bit times.
  task automatic applyStimulus(input vec_t v);
    int p = v.len + 1;
    int dur;
    int nstop_seen = 0;
    @(negedge i_clk);
    i_bit_length  = 32'(v.len);
    i_data_bits   = v.dbits;
    i_parity_mode = v.par;
    i_stop_bits   = v.stop;
    i_msb_first   = v.msb;
    i_enable      = 1'b1;
    build_line(v);
    i_rx = 1'b0;
    repeat (p) @(negedge i_clk);
    i_bit_length  = 32'($urandom_range(3, 40));
    i_data_bits   = 4'($urandom);
    i_parity_mode = 2'($urandom);
    i_stop_bits   = 2'($urandom);
    i_msb_first   = 1'($urandom);
    i_enable      = 1'($urandom);
    foreach (line_q[i]) begin
      i_rx = line_q[i];
      dur  = p;
      if (i >= eff_bits(v.dbits) + ((v.par == 2'b01 || v.par == 2'b10) ? 1 : 0)) begin
        if (nstop_seen == 0 && v.stop == 2'b01) dur = p + p / 2;
        nstop_seen++;
      end
      repeat (dur) @(negedge i_clk);
    end
    i_rx     = 1'b1;
    i_enable = 1'b1;
    repeat (2 * p) @(negedge i_clk);
  endtask

  task automatic checkFrame(input string tag, input res_t e);
    checkOutput($sformatf("%s.count", tag), 32'(capq.size()), 32'd1);
    if (capq.size() >= 1) begin
      checkOutput($sformatf("%s.data", tag), 32'(capq[0].data), 32'(e.data));
      checkOutput($sformatf("%s.perr", tag), 32'(capq[0].perr), 32'(e.perr));
      checkOutput($sformatf("%s.ferr", tag), 32'(capq[0].ferr), 32'(e.ferr));
      checkOutput($sformatf("%s.brk",  tag), 32'(capq[0].brk),  32'(e.brk));
    end
    checkOutput($sformatf("%s.busy", tag), 32'(o_busy), 32'd0);
    capq.delete();
  endtask

  initial begin
    vec_t v;
    res_t e;

    //            len dbits par   stop  msb  word   flp s2z  exp_d  pe ferr brk
    vecs[0] = '{15, 4'd8, 2'd0, 2'd0, 1'b0, 9'h0A5, 0, 0, 9'h0A5, 0, 0, 0};
    vecs[1] = '{15, 4'd7, 2'd1, 2'd2, 1'b1, 9'h055, 0, 0, 9'h055, 0, 0, 0};
    vecs[2] = '{15, 4'd7, 2'd1, 2'd2, 1'b1, 9'h055, 1, 0, 9'h055, 1, 0, 0};
    vecs[3] = '{15, 4'd9, 2'd2, 2'd2, 1'b0, 9'h1FF, 0, 0, 9'h1FF, 0, 0, 0};
    vecs[4] = '{15, 4'd9, 2'd2, 2'd2, 1'b0, 9'h1FF, 0, 1, 9'h1FF, 0, 1, 0};
    vecs[5] = '{12, 4'd3, 2'd0, 2'd1, 1'b1, 9'h013, 0, 0, 9'h013, 0, 0, 0};

    i_nrst = 1'b0; i_rx = 1'b1; i_enable = 1'b1;
    i_bit_length = 32'd15; i_data_bits = 4'd8; i_parity_mode = 2'd0;
    i_stop_bits = 2'd0; i_msb_first = 1'b0;
    i_hw_flow_control_enable = 1'b0; bus.i_fifo_almfull = 1'b0;
    repeat (3) @(negedge i_clk);
    checkOutput("reset.valid", 32'(bus.o_valid), 32'd0);
    checkOutput("reset.data",  32'(bus.o_data), 32'd0);
    checkOutput("reset.perr",  32'(bus.o_parity_error), 32'd0);
    checkOutput("reset.ferr",  32'(bus.o_frame_error), 32'd0);
    checkOutput("reset.brk",   32'(bus.o_break), 32'd0);
    checkOutput("reset.busy",  32'(o_busy), 32'd0);
    checkOutput("reset.rts",   32'(bus.o_rts), 32'd1);
    i_nrst = 1'b1;
    repeat (4) @(negedge i_clk);

    $display("[TB] table-driven frames");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      checkFrame($sformatf("vec%0d", i), '{vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr, vecs[i].exp_brk});
    end

    $display("[TB] randomized frames");
    for (int i = 0; i < 24; i++) begin
      v.len        = $urandom_range(7, 20);
      v.dbits      = 4'($urandom);
      v.par        = 2'($urandom);
      v.stop       = 2'($urandom);
      v.msb        = 1'($urandom);
      v.word       = 9'($urandom & ((1 << eff_bits(v.dbits)) - 1));
      v.flip_par   = 1'($urandom);
      v.stop2_zero = (v.stop >= 2) && ($urandom_range(0, 3) == 0);
      build_line(v);
      e = model(v);
      applyStimulus(v);
      checkFrame($sformatf("rnd%0d", i), e);
    end

    $display("[TB] false start");
    @(negedge i_clk);
    i_bit_length = 32'd15; i_data_bits = 4'd8; i_parity_mode = 2'd0;
    i_stop_bits = 2'd0; i_msb_first = 1'b0;
    i_rx = 1'b0;
    repeat (5) @(negedge i_clk);
    checkOutput("false_start.busy_in", 32'(o_busy), 32'd1);
    i_rx = 1'b1;
    repeat (40) @(negedge i_clk);
    checkOutput("false_start.count", 32'(capq.size()), 32'd0);
    checkOutput("false_start.busy_out", 32'(o_busy), 32'd0);
    capq.delete();

    $display("[TB] break");
    i_rx = 1'b0;
    repeat (20 * 16) @(negedge i_clk);
    checkFrame_break: begin
      checkOutput("break.count", 32'(capq.size()), 32'd1);
      if (capq.size() >= 1) begin
        checkOutput("break.data", 32'(capq[0].data), 32'd0);
        checkOutput("break.brk",  32'(capq[0].brk),  32'd1);
        checkOutput("break.ferr", 32'(capq[0].ferr), 32'd1);
      end
    end
    checkOutput("break.busy_wait", 32'(o_busy), 32'd1);
    repeat (3 * 16) @(negedge i_clk);
    checkOutput("break.no_more", 32'(capq.size()), 32'd1);
    i_rx = 1'b1;
    repeat (32) @(negedge i_clk);
    checkOutput("break.busy_after", 32'(o_busy), 32'd0);
    capq.delete();
    applyStimulus(vecs[0]);
    checkFrame("after_break", '{9'h0A5, 1'b0, 1'b0, 1'b0});

    $display("[TB] flow control");
    @(negedge i_clk);
    i_hw_flow_control_enable = 1'b1; bus.i_fifo_almfull = 1'b0;
    repeat (2) @(negedge i_clk);
    checkOutput("rts.high", 32'(bus.o_rts), 32'd1);
    bus.i_fifo_almfull = 1'b1;
    #1;
    checkOutput("rts.lag", 32'(bus.o_rts), 32'd1);
    @(negedge i_clk);
    checkOutput("rts.low", 32'(bus.o_rts), 32'd0);
    i_hw_flow_control_enable = 1'b0;
    @(negedge i_clk);
    checkOutput("rts.fc_off", 32'(bus.o_rts), 32'd1);
    bus.i_fifo_almfull = 1'b0;

    $display("[TB] reset mid-frame");
    i_rx = 1'b0; repeat (16) @(negedge i_clk);
    i_rx = 1'b1; repeat (16) @(negedge i_clk);
    i_rx = 1'b0; repeat (8)  @(negedge i_clk);
    checkOutput("midrst.busy_before", 32'(o_busy), 32'd1);
    i_nrst = 1'b0;
    #1;
    checkOutput("midrst.busy", 32'(o_busy), 32'd0);
    checkOutput("midrst.data", 32'(bus.o_data), 32'd0);
    i_rx = 1'b1;
    repeat (3) @(negedge i_clk);
    i_nrst = 1'b1;
    repeat (200) @(negedge i_clk);
    checkOutput("midrst.count", 32'(capq.size()), 32'd0);
    capq.delete();
    applyStimulus(vecs[1]);
    checkFrame("after_reset", '{9'h055, 1'b0, 1'b0, 1'b0});

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
